// File: rtl/chan_pkt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : chan_pkt_pkg
// Brief    : Shared constants, state encoding and trailer helper for chan_packer
// Revision : 1.0
// ============================================================================
package chan_pkt_pkg;

    localparam int DATA_W  = 13;
    localparam int FIELD_W = 16;
    localparam int WORD_W  = 32;
    localparam int CNT_W   = 12;
    localparam int CHAN_W  = 3;

    localparam logic [15:0] HDR_MAGIC = 16'hA55A;
    localparam logic [2:0]  TRL_TAG   = 3'b111;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_HDR  = 3'd1;
    localparam state_t ST_DATA = 3'd2;
    localparam state_t ST_PAD  = 3'd3;
    localparam state_t ST_TRL  = 3'd4;

    function automatic logic [WORD_W-1:0] trailer_word(
        input logic             trunc,
        input logic [CNT_W-1:0] count,
        input logic [15:0]      csum
    );
        return {TRL_TAG, trunc, count, csum};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pkt_fifo
// Brief    : Synchronous first-word-fall-through FIFO with occupancy output
// Revision : 1.0
// ============================================================================
module pkt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_wr_en,
    input  logic [WIDTH-1:0]           i_wr_data,
    input  logic                       i_rd_en,
    output logic [WIDTH-1:0]           o_rd_data,
    output logic                       o_empty,
    output logic                       o_full,
    output logic [$clog2(DEPTH):0]     o_used
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_used;
    logic             w_rd;
    logic             w_wr;

    // A write into a full FIFO is accepted when the head leaves in the same cycle
    assign w_rd = i_rd_en & (r_used != '0);
    assign w_wr = i_wr_en & ((r_used != C_DEPTH) | w_rd);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_used   <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_used <= r_used + (AW+1)'(w_wr) - (AW+1)'(w_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
    end

    assign o_empty   = (r_used == '0);
    assign o_full    = (r_used == C_DEPTH);
    assign o_used    = r_used;
    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/chan_packer.sv
`default_nettype none
// ============================================================================
// Module   : chan_packer
// Brief    : Pulls 13-bit samples, packs two per word, wraps each line in header/trailer
// Revision : 1.0
// ============================================================================
module chan_packer
    import chan_pkt_pkg::*;
#(
    parameter int                 SAMPLES = 512,
    parameter logic [CHAN_W-1:0]  CHAN_ID = '0
) (
    input  logic              clk,
    input  logic              res,
    input  logic              sync_n,
    input  logic              valid,
    input  logic [DATA_W-1:0] data,
    output logic              dst_ready,
    output logic [WORD_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last
);
    localparam logic [CNT_W-1:0] C_SAMPLES = CNT_W'(SAMPLES);

    state_t               r_state;
    logic                 r_sync_tmp;
    logic                 r_pend;
    logic                 r_trunc;
    logic                 r_half_vld;
    logic [FIELD_W-1:0]   r_half;
    logic [CNT_W-1:0]     r_count;
    logic [15:0]          r_csum;
    logic [15:0]          r_frame_cnt;

    logic                 w_rise;
    logic                 w_acc;
    logic                 w_end;
    logic                 w_half_next;
    logic [FIELD_W-1:0]   w_field;
    logic                 w_wr_en;
    logic [WORD_W:0]      w_wr_data;
    logic [WORD_W:0]      w_rd_data;
    logic                 w_empty;
    logic                 w_full;
    logic [2:0]           w_used;

    assign w_rise  = sync_n & ~r_sync_tmp;
    assign w_field = {CHAN_ID, data};

    // Registers only: upstream valid is already a function of dst_ready
    assign dst_ready = (r_state == ST_DATA) && (r_count < C_SAMPLES) && (w_used <= 3'd2);
    assign w_acc     = valid & dst_ready;

    assign w_end       = (r_count == C_SAMPLES) || (w_rise && (r_count != '0));
    assign w_half_next = w_acc ? ~r_half_vld : r_half_vld;

    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_data = '0;
        case (r_state)
            ST_HDR: begin
                w_wr_en   = ~w_full;
                w_wr_data = {1'b0, HDR_MAGIC, r_frame_cnt};
            end
            ST_DATA: begin
                w_wr_en   = w_acc & r_half_vld;
                w_wr_data = {1'b0, w_field, r_half};
            end
            ST_PAD: begin
                w_wr_en   = ~w_full;
                w_wr_data = {1'b0, {FIELD_W{1'b0}}, r_half};
            end
            ST_TRL: begin
                w_wr_en   = ~w_full;
                w_wr_data = {1'b1, trailer_word(r_trunc, r_count, r_csum)};
            end
            default: begin
                w_wr_en   = 1'b0;
                w_wr_data = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            r_state     <= ST_IDLE;
            r_sync_tmp  <= 1'b1;
            r_pend      <= 1'b0;
            r_trunc     <= 1'b0;
            r_half_vld  <= 1'b0;
            r_half      <= '0;
            r_count     <= '0;
            r_csum      <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_sync_tmp <= sync_n;
            if (w_acc) begin
                r_half_vld <= ~r_half_vld;
                if (!r_half_vld) r_half <= w_field;
                r_count <= r_count + 1'b1;
                r_csum  <= r_csum + {{(16-DATA_W){1'b0}}, data};
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) r_state <= ST_HDR;
                end
                ST_HDR: begin
                    if (w_wr_en) begin
                        r_count    <= '0;
                        r_csum     <= '0;
                        r_trunc    <= 1'b0;
                        r_half_vld <= 1'b0;
                        r_state    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_end) begin
                        // A complete line closed by a coincident sync is not truncated
                        if (w_rise) r_pend <= 1'b1;
                        if (w_rise && (r_count < C_SAMPLES)) r_trunc <= 1'b1;
                        r_state <= w_half_next ? ST_PAD : ST_TRL;
                    end
                end
                ST_PAD: begin
                    if (w_rise) r_pend <= 1'b1;
                    if (w_wr_en) begin
                        r_half_vld <= 1'b0;
                        r_state    <= ST_TRL;
                    end
                end
                ST_TRL: begin
                    if (w_wr_en) begin
                        r_frame_cnt <= r_frame_cnt + 1'b1;
                        r_pend      <= 1'b0;
                        r_state     <= (r_pend | w_rise) ? ST_HDR : ST_IDLE;
                    end else if (w_rise) begin
                        r_pend <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    pkt_fifo #(
        .DEPTH (4),
        .WIDTH (WORD_W + 1)
    ) u_fifo (
        .clk       (clk),
        .rst       (res),
        .i_wr_en   (w_wr_en),
        .i_wr_data (w_wr_data),
        .i_rd_en   (m_ready),
        .o_rd_data (w_rd_data),
        .o_empty   (w_empty),
        .o_full    (w_full),
        .o_used    (w_used)
    );

    assign m_valid = ~w_empty;
    assign m_data  = w_rd_data[WORD_W-1:0];
    assign m_last  = w_rd_data[WORD_W];

endmodule
`default_nettype wire
